// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: key codes, op_sel encodings seen by the
// arithmetic unit, and the entry-controller state type.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_CLR = 4'd14;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        DONE
    } calcState_t;

    function automatic logic [1:0] keyToOp(input logic [3:0] keyCode);
        case (keyCode)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bcd_operand_reg.sv
// Two-digit BCD operand: digits shift in from the right and saturate at two.
// Asserting clear together with load_digit restarts the operand with that digit.
module bcd_operand_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_digit,
    input  logic [3:0] digit,
    input  logic       clear,
    output logic       full,
    output logic [7:0] value
);

    logic [1:0] digitCount;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value      <= 8'h00;
            digitCount <= 2'd0;
        end else if (clear) begin
            value      <= load_digit ? {4'h0, digit} : 8'h00;
            digitCount <= load_digit ? 2'd1 : 2'd0;
        end else if (load_digit && !full) begin
            value      <= {value[3:0], digit};
            digitCount <= digitCount + 2'd1;
        end
    end

    assign full = (digitCount == 2'd2);

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad operand entry controller: builds A, op, B from key events and holds
// them stable for the combinational arithmetic unit while the result shows.
module calc_entry_ctrl
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] operandA,
    output logic [7:0] operandB,
    output logic [1:0] op_sel,
    output logic       result_valid,
    output logic [7:0] disp,
    output logic       key_reject
);

    calcState_t state, nextState;
    logic       loadA, clearA, loadB, clearB;
    logic       fullA, fullB;
    logic       opLoad, rejectNext;
    logic [1:0] opNext;
    logic       bEntered;
    logic       isDigit, isOp, isEq, isClr;

    assign isDigit = (key_code <= 4'd9);
    assign isOp    = (key_code >= KEY_ADD) && (key_code <= KEY_MUL);
    assign isEq    = (key_code == KEY_EQ);
    assign isClr   = (key_code == KEY_CLR);

    bcd_operand_reg uOperandA (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_digit(loadA),
        .digit     (key_code),
        .clear     (clearA),
        .full      (fullA),
        .value     (operandA)
    );

    bcd_operand_reg uOperandB (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_digit(loadB),
        .digit     (key_code),
        .clear     (clearB),
        .full      (fullB),
        .value     (operandB)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ENTER_A;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (key_valid) begin
            if (isClr) begin
                nextState = ENTER_A;
            end else begin
                case (state)
                    ENTER_A: if (isOp) nextState = ENTER_B;
                    ENTER_B: if (isEq && bEntered) nextState = DONE;
                    DONE:    if (isDigit) nextState = ENTER_A;
                    default: nextState = ENTER_A;
                endcase
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        loadA      = 1'b0;
        clearA     = 1'b0;
        loadB      = 1'b0;
        clearB     = 1'b0;
        opLoad     = 1'b0;
        opNext     = OP_NONE;
        rejectNext = 1'b0;
        if (key_valid) begin
            if (isClr) begin
                clearA = 1'b1;
                clearB = 1'b1;
                opLoad = 1'b1;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (isDigit) begin
                            loadA      = 1'b1;
                            rejectNext = fullA;
                        end else if (isOp) begin
                            opLoad = 1'b1;
                            opNext = keyToOp(key_code);
                            clearB = 1'b1;
                        end else begin
                            rejectNext = 1'b1;
                        end
                    end
                    ENTER_B: begin
                        if (isDigit) begin
                            loadB      = 1'b1;
                            rejectNext = fullB;
                        end else if (isOp) begin
                            // The operator may be changed only until B has a digit.
                            opLoad     = !bEntered;
                            opNext     = keyToOp(key_code);
                            rejectNext = bEntered;
                        end else if (isEq) begin
                            rejectNext = !bEntered;
                        end else begin
                            rejectNext = 1'b1;
                        end
                    end
                    DONE: begin
                        if (isDigit) begin
                            clearA = 1'b1;
                            loadA  = 1'b1;
                            clearB = 1'b1;
                            opLoad = 1'b1;
                        end else begin
                            rejectNext = 1'b1;
                        end
                    end
                    default: rejectNext = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_sel     <= OP_NONE;
            key_reject <= 1'b0;
            bEntered   <= 1'b0;
        end else begin
            key_reject <= rejectNext;
            if (opLoad) op_sel <= opNext;
            if (clearB)     bEntered <= 1'b0;
            else if (loadB) bEntered <= 1'b1;
        end
    end

    assign result_valid = (state == DONE);
    assign disp         = (state == ENTER_A) ? operandA : operandB;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl: directed keys push hand-computed
// expectations, a monitor pops and compares one entry per clock after each key.
module tb_calc_entry_ctrl;
    import calc_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       rv;
        logic       rej;
        logic [7:0] d;
    } expT;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] operandA, operandB, disp;
    logic [1:0] op_sel;
    logic       result_valid, key_reject;

    expT expQ[$];
    expT lastExp;
    int  testsRun = 0;
    int  testsFailed = 0;

    calc_entry_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .operandA    (operandA),
        .operandB    (operandB),
        .op_sel      (op_sel),
        .result_valid(result_valid),
        .disp        (disp),
        .key_reject  (key_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        testsRun++;
        if (act !== expv) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkAll(input string tag, input expT e);
        check({tag, " operandA"}, operandA, e.a);
        check({tag, " operandB"}, operandB, e.b);
        check({tag, " op_sel"}, 8'(op_sel), 8'(e.op));
        check({tag, " result_valid"}, 8'(result_valid), 8'(e.rv));
        check({tag, " key_reject"}, 8'(key_reject), 8'(e.rej));
        check({tag, " disp"}, disp, e.d);
    endtask

    // Monitor: every edge that follows an issued key or idle cycle is compared.
    always begin
        @(posedge clk);
        #1;
        if (rst_n && expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            checkAll("key", e);
        end
    end

    task automatic press(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic rv, input logic rej,
                         input logic [7:0] d);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        lastExp   = '{a: a, b: b, op: op, rv: rv, rej: rej, d: d};
        expQ.push_back(lastExp);
    endtask

    task automatic idle();
        @(negedge clk);
        key_valid   = 1'b0;
        key_code    = 4'd0;
        lastExp.rej = 1'b0;
        expQ.push_back(lastExp);
    endtask

    task automatic asyncReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        lastExp = '{a: 8'h00, b: 8'h00, op: OP_NONE, rv: 1'b0, rej: 1'b0, d: 8'h00};
        checkAll("reset", lastExp);
        @(negedge clk);
        key_valid = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        #3;
        asyncReset();

        // Normal calculation 42 + 17 =
        press(4'd4,    8'h04, 8'h00, OP_NONE, 0, 0, 8'h04);
        press(4'd2,    8'h42, 8'h00, OP_NONE, 0, 0, 8'h42);
        press(KEY_ADD, 8'h42, 8'h00, OP_ADD,  0, 0, 8'h00);
        press(4'd1,    8'h42, 8'h01, OP_ADD,  0, 0, 8'h01);
        press(4'd7,    8'h42, 8'h17, OP_ADD,  0, 0, 8'h17);
        press(KEY_EQ,  8'h42, 8'h17, OP_ADD,  1, 0, 8'h17);
        idle();
        // Rejections in DONE leave everything frozen
        press(4'd15,   8'h42, 8'h17, OP_ADD,  1, 1, 8'h17);
        press(KEY_ADD, 8'h42, 8'h17, OP_ADD,  1, 1, 8'h17);
        press(KEY_EQ,  8'h42, 8'h17, OP_ADD,  1, 1, 8'h17);
        // New digit from DONE, then overflow in A
        press(4'd1,    8'h01, 8'h00, OP_NONE, 0, 0, 8'h01);
        press(4'd2,    8'h12, 8'h00, OP_NONE, 0, 0, 8'h12);
        press(4'd3,    8'h12, 8'h00, OP_NONE, 0, 1, 8'h12);
        press(4'd15,   8'h12, 8'h00, OP_NONE, 0, 1, 8'h12);
        press(KEY_EQ,  8'h12, 8'h00, OP_NONE, 0, 1, 8'h12);
        idle();

        // Asynchronous reset mid-entry, then first key after release
        asyncReset();
        press(4'd7,    8'h07, 8'h00, OP_NONE, 0, 0, 8'h07);

        // Equals with empty B, operator change, locked operator
        press(4'd5,    8'h75, 8'h00, OP_NONE, 0, 0, 8'h75);
        press(KEY_MUL, 8'h75, 8'h00, OP_MUL,  0, 0, 8'h00);
        press(KEY_EQ,  8'h75, 8'h00, OP_MUL,  0, 1, 8'h00);
        press(4'd15,   8'h75, 8'h00, OP_MUL,  0, 1, 8'h00);
        press(KEY_SUB, 8'h75, 8'h00, OP_SUB,  0, 0, 8'h00);
        press(4'd3,    8'h75, 8'h03, OP_SUB,  0, 0, 8'h03);
        press(KEY_ADD, 8'h75, 8'h03, OP_SUB,  0, 1, 8'h03);
        press(4'd4,    8'h75, 8'h34, OP_SUB,  0, 0, 8'h34);
        press(4'd5,    8'h75, 8'h34, OP_SUB,  0, 1, 8'h34);
        press(KEY_EQ,  8'h75, 8'h34, OP_SUB,  1, 0, 8'h34);
        press(KEY_CLR, 8'h00, 8'h00, OP_NONE, 0, 0, 8'h00);

        // 99 * 99 =, then a digit restarts the calculation
        press(4'd9,    8'h09, 8'h00, OP_NONE, 0, 0, 8'h09);
        press(4'd9,    8'h99, 8'h00, OP_NONE, 0, 0, 8'h99);
        press(KEY_MUL, 8'h99, 8'h00, OP_MUL,  0, 0, 8'h00);
        press(4'd9,    8'h99, 8'h09, OP_MUL,  0, 0, 8'h09);
        press(4'd9,    8'h99, 8'h99, OP_MUL,  0, 0, 8'h99);
        press(KEY_EQ,  8'h99, 8'h99, OP_MUL,  1, 0, 8'h99);
        press(4'd9,    8'h09, 8'h00, OP_NONE, 0, 0, 8'h09);

        // Back-to-back identical keys, op with empty A, clear from ENTER_B
        press(KEY_CLR, 8'h00, 8'h00, OP_NONE, 0, 0, 8'h00);
        press(4'd8,    8'h08, 8'h00, OP_NONE, 0, 0, 8'h08);
        press(4'd8,    8'h88, 8'h00, OP_NONE, 0, 0, 8'h88);
        press(KEY_CLR, 8'h00, 8'h00, OP_NONE, 0, 0, 8'h00);
        press(KEY_ADD, 8'h00, 8'h00, OP_ADD,  0, 0, 8'h00);
        press(4'd6,    8'h00, 8'h06, OP_ADD,  0, 0, 8'h06);
        press(KEY_CLR, 8'h00, 8'h00, OP_NONE, 0, 0, 8'h00);
        idle();

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard drained", 8'(expQ.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
